// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: registered ownership, round-robin between the
// CPU port (0) and a secondary master (1), with bounded lock for RMW sequences.
module dm_arbiter #(
  parameter int ADDR_BITS = 12,
  parameter int MAX_LOCK  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        lock0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic [3:0]  byteen0,
  output logic        ack0,
  output logic        err0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        lock1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic [3:0]  byteen1,
  output logic        ack1,
  output logic        err1,
  output logic [31:0] rdata1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  owner
);
  localparam int LW = $clog2(MAX_LOCK) + 1;
  localparam logic [32:0] LIMIT = 33'(4) << ADDR_BITS;
  localparam logic [LW-1:0] LMAX = LW'(MAX_LOCK - 1);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_P0 = 2'd1, OWN_P1 = 2'd2} own_t;

  own_t          r_owner;
  logic          r_last;
  logic [LW-1:0] r_lcnt;

  logic w_own0, w_own1, w_err0, w_err1;
  logic w_keep0, w_keep1, w_el0, w_el1;

  assign w_own0 = (r_owner == OWN_P0);
  assign w_own1 = (r_owner == OWN_P1);
  assign w_err0 = {1'b0, addr0} >= LIMIT;
  assign w_err1 = {1'b0, addr1} >= LIMIT;

  // Reset in an owned cycle kills the ack and the write strobe immediately.
  assign ack0   = w_own0 & ~reset;
  assign ack1   = w_own1 & ~reset;
  assign err0   = ack0 & w_err0;
  assign err1   = ack1 & w_err1;
  assign rdata0 = ack0 ? mem_rdata : 32'h0;
  assign rdata1 = ack1 ? mem_rdata : 32'h0;
  assign owner  = r_owner;

  always_comb begin
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    mem_byteen = 4'h0;
    mem_we     = 1'b0;
    if (w_own0) begin
      mem_addr   = addr0;
      mem_wdata  = wdata0;
      mem_byteen = byteen0;
      mem_we     = we0 & ~w_err0 & ~reset;
    end else if (w_own1) begin
      mem_addr   = addr1;
      mem_wdata  = wdata1;
      mem_byteen = byteen1;
      mem_we     = we1 & ~w_err1 & ~reset;
    end
  end

  assign w_keep0 = w_own0 & lock0 & req0 & (~req1 | (r_lcnt < LMAX));
  assign w_keep1 = w_own1 & lock1 & req1 & (~req0 | (r_lcnt < LMAX));
  // The port acked this cycle is excluded so it cannot win twice in a row.
  assign w_el0   = req0 & ~w_own0;
  assign w_el1   = req1 & ~w_own1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= OWN_NONE;
      r_last  <= 1'b1;
      r_lcnt  <= '0;
    end else if (w_keep0 | w_keep1) begin
      // Saturates while uncontended so a late requester forces release promptly.
      if (r_lcnt < LMAX) r_lcnt <= r_lcnt + LW'(1);
    end else if (w_el0 & w_el1) begin
      r_owner <= r_last ? OWN_P0 : OWN_P1;
      r_last  <= ~r_last;
      r_lcnt  <= '0;
    end else if (w_el0) begin
      r_owner <= OWN_P0;
      r_last  <= 1'b0;
      r_lcnt  <= '0;
    end else if (w_el1) begin
      r_owner <= OWN_P1;
      r_last  <= 1'b1;
      r_lcnt  <= '0;
    end else begin
      r_owner <= OWN_NONE;
      r_lcnt  <= '0;
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small byte-lane memory behind it.
module tb_dm_arbiter;
  localparam int AB = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0, lock0, we0, req1, lock1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [3:0]  byteen0, byteen1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [3:0]  mem_byteen;
  logic [1:0]  owner;

  dm_arbiter #(.ADDR_BITS(AB), .MAX_LOCK(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .byteen0(byteen0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .byteen1(byteen1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_byteen(mem_byteen),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  logic [31:0] mem [0:(1<<AB)-1];
  assign mem_rdata = mem[mem_addr[AB+1:2]];
  always @(posedge clk)
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_byteen[b]) mem[mem_addr[AB+1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic clear_ins;
    req0 = 0; lock0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; byteen0 = 0;
    req1 = 0; lock1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; byteen1 = 0;
  endtask

  task automatic do_reset;
    reset = 1; clear_ins(); step(); reset = 0;
  endtask

  // Issues one access on port p, waits (bounded) for its ack, then drops req.
  task automatic access(input bit p, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output int lat, output logic [31:0] rd,
                        output logic er, output logic mwe);
    lat = 0; rd = 0; er = 0; mwe = 0;
    if (!p) begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; byteen0 = be; end
    else    begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; byteen1 = be; end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (p ? ack1 : ack0) begin
        lat = i; rd = p ? rdata1 : rdata0; er = p ? err1 : err0; mwe = mem_we;
        break;
      end
    end
    step();
    if (!p) req0 = 0; else req1 = 0;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er, mwe;

  initial begin
    reset = 1; clear_ins();
    step(); step();
    @(negedge clk);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_ack0", 32'(ack0), 0);
    chk("rst_ack1", 32'(ack1), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_rdata0", rdata0, 0);
    step(); reset = 0;

    // basic write then readback
    access(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er, mwe);
    chk("wr_latency", 32'(lat), 2);
    chk("wr_mem_we", 32'(mwe), 1);
    chk("wr_err", 32'(er), 0);
    @(negedge clk);
    chk("no_back2back", 32'(owner), 0);
    chk("wr_commit", mem[4], 32'hDEADBEEF);
    step();
    access(0, 0, 32'h10, 0, 4'h0, lat, rd, er, mwe);
    chk("rd_latency", 32'(lat), 2);
    chk("rd_data", rd, 32'hDEADBEEF);

    access(0, 1, 32'h0,  32'hCAFEF00D, 4'hF, lat, rd, er, mwe);
    access(0, 1, 32'h14, 32'h11223344, 4'hF, lat, rd, er, mwe);
    access(0, 1, 32'h20, 32'h12345678, 4'hF, lat, rd, er, mwe);
    chk("preload", mem[5], 32'h11223344);

    // contention without lock: P0 first after reset, then alternating
    reset = 1; clear_ins(); step();
    req0 = 1; addr0 = 32'h10; req1 = 1; addr1 = 32'h14; reset = 0;
    @(negedge clk);
    chk("ctn_idle", 32'(owner), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("ctn_acks%0d", i), 32'({ack1, ack0}), (i % 2) ? 32'd2 : 32'd1);
    end

    // lock: eight ack0 in a row, then P1
    reset = 1; clear_ins(); step();
    req0 = 1; lock0 = 1; addr0 = 32'h10; req1 = 1; addr1 = 32'h14; reset = 0;
    @(negedge clk);
    chk("lock_idle", 32'(owner), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("lock_ack0_%0d", i), 32'({ack1, ack0}), 1);
    end
    @(negedge clk);
    chk("lock_release", 32'({ack1, ack0}), 2);
    chk("lock_rdata1", rdata1, 32'h11223344);
    chk("lock_lcnt", 32'(dut.r_lcnt), 0);
    do_reset();

    // out-of-range write is acked, flagged and suppressed
    access(1, 1, 32'h4000, 32'h55555555, 4'hF, lat, rd, er, mwe);
    chk("oor_latency", 32'(lat), 2);
    chk("oor_err", 32'(er), 1);
    chk("oor_mem_we", 32'(mwe), 0);
    chk("oor_unchanged", mem[0], 32'hCAFEF00D);

    // single byte-lane write
    access(1, 1, 32'h14, 32'h0000AB00, 4'b0010, lat, rd, er, mwe);
    chk("be_mem_we", 32'(mwe), 1);
    access(1, 0, 32'h14, 0, 4'h0, lat, rd, er, mwe);
    chk("be_latency", 32'(lat), 2);
    chk("be_readback", rd, 32'h1122AB44);

    // request withdrawn before any edge sees it
    req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h0; byteen0 = 4'hF;
    @(negedge clk);
    req0 = 0;
    @(negedge clk);
    chk("withdraw_owner", 32'(owner), 0);
    chk("withdraw_ack", 32'(ack0), 0);

    // reset during a write ack cycle
    step();
    req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'hFFFFFFFF; byteen0 = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("rstack_pre", 32'(ack0), 1);
    reset = 1; #1;
    chk("rstack_ack0", 32'(ack0), 0);
    chk("rstack_mem_we", 32'(mem_we), 0);
    @(posedge clk); #1;
    reset = 0; req0 = 0;
    @(negedge clk);
    chk("rstack_owner", 32'(owner), 0);
    chk("rstack_unchanged", mem[8], 32'h12345678);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
